coax_rx_buffer: RTL
===================

Name: coax_rx_buffer

Overview:
- Parametrised receive buffer between the coax RX word decoder and control; successor to the fixed 10-bit/256-entry buffered receiver.
- Stores decoded words with a per-word end-of-frame flag.
- Keeps sticky overflow and error status.
- Offers two overflow policies: drop the newest word, or discard the whole frame with the write pointer rewound to frame start.

Parameters:
- DATA_WIDTH, 10, width of one decoded coax word.
- DEPTH, 256, number of FIFO entries; power of two, at least 4.
- OVERFLOW_MODE, 0, 0 = drop newest word; 1 = frame-atomic, so the reader only sees complete, error-free frames.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; clears data and sticky flags.
- in_data  input  DATA_WIDTH  decoded word.
- in_strobe  input  1  one-cycle pulse; in_data valid.
- in_active  input  1  decoder is inside a frame.
- in_error  input  1  one-cycle pulse; decoder detected an error.
- read_strobe  input  1  pop the head word.
- data  output  DATA_WIDTH  head word (first-word fall-through).
- eof  output  1  head word is the last word of its frame.
- empty  output  1  no readable word.
- full  output  1  no free entry.
- level  output  $clog2(DEPTH)+1  count of readable words.
- overflow  output  1  sticky: at least one word or frame was lost.
- error  output  1  sticky: in_error was seen.

Behaviour:
- **Reset (reset_n low, asynchronous):**
  - All pointers, the pending register, state and sticky flags go to 0.
  - empty=1, full=0, level=0, overflow=0, error=0.
  - data and eof read 0.
- **clear (synchronous):** same effect as reset. It beats every same-cycle input, and a word or strobe arriving in that cycle is lost.
- **One-word pending register:**
  - On in_strobe, the previous pending word (if any) is written with eof=0, and in_data becomes the new pending word.
  - On the in_active 1->0 edge, the pending word (if any) is written with eof=1 and the pending register empties.
  - in_strobe and the in_active falling edge in the same cycle: write the old pending word with eof=0, then write the new word with eof=1 on the next cycle (holding-cycle rule). A fresh in_strobe cannot arrive within 1 cycle of a frame end.
- **Write latency:** a word is written to RAM one event after arrival, as above. Once written, it is readable the next cycle (empty falls at N+1 for a write at N).
- **Read:**
  - read_strobe with !empty advances the read pointer. data/eof show the new head on the next cycle.
  - read_strobe while empty is ignored; no pointer or flag changes.
- **Simultaneous read and write:** full is judged before the read, so a write is refused when full even if a read happens in the same cycle. level stays consistent: +1 write, −1 read, 0 for both.
- **Pointers:** wrap modulo DEPTH; an extra MSB tells full from empty.
- **OVERFLOW_MODE 0:**
  - A write attempted while full drops that word and sets overflow.
  - If that word carried eof, the eof is lost too.
  - in_error sets error; words are kept.
  - Words are readable as soon as they are written.
- **OVERFLOW_MODE 1:** states are IDLE, RECV, DISCARD.
  - IDLE→RECV on the first in_strobe while in_active. frame_start_ptr is latched to the current write pointer.
  - Writes advance wr_ptr. The reader boundary commit_ptr only advances to wr_ptr on the eof write. level, empty and full are computed from commit_ptr and rd_ptr; the write check uses wr_ptr.
  - RECV→DISCARD if a write is attempted while wr_ptr is full, or if in_error arrives: wr_ptr←frame_start_ptr, pending is dropped, overflow (full case) or error (error case) is set.
  - DISCARD ignores all in_strobe and returns to IDLE on the in_active falling edge. No words from that frame become visible.
  - RECV→IDLE after the eof write commits.
  - A frame larger than DEPTH is always discarded.
- in_error outside a frame sets error only.
- Sticky flags clear only on reset_n or clear.

Test Plan:
1. **Mode 0, 3-word frame:** send 0x101, 0x202, 0x303, then drop in_active.
   - empty falls 1 cycle after the second strobe; level reaches 3.
   - Reads return 0x101/eof0, 0x202/eof0, 0x303/eof1.
   - Then empty=1 and level=0.
2. **Mode 0, DEPTH=4:** send a 6-word frame with no reads.
   - full=1 and level=4, holding words 1–4 with eof=0; overflow=1.
   - A read then pop returns words 1–4 in order.
3. **Mode 1, DEPTH=8:** send a committed 2-word frame, then a 10-word frame.
   - Only the 2-word frame is readable (level=2, second word eof=1); overflow=1.
   - A following 3-word frame is stored from the rewound pointer; level=5.
4. **Mode 1, error mid-frame:** in_error after word 2 of a 4-word frame.
   - empty stays 1 and error=1; the frame is not visible.
   - The next clean frame is readable intact.
5. **Wrap-around, DEPTH=4:** interleave 10 single-word frames with reads.
   - Data matches across pointer wrap; every word has eof=1.
   - Read while empty is ignored (level stays 0).
6. **reset_n low mid-frame (asynchronous):** outputs go to reset values immediately.
   - clear in the same cycle as in_strobe drops that word.
   - Sticky flags return to 0.

Source files
------------

// File: rtl/coax_rx_buffer.sv
// Receive buffer between the coax word decoder and control: stores decoded words with an
// end-of-frame flag, tracks sticky overflow/error, and optionally keeps frames atomic.
module coax_rx_buffer #(
  parameter int DATA_WIDTH    = 10,
  parameter int DEPTH         = 256,
  parameter int OVERFLOW_MODE = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_strobe,
  input  logic                    in_active,
  input  logic                    in_error,
  input  logic                    read_strobe,
  output logic [DATA_WIDTH-1:0]   data,
  output logic                    eof,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    error
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] CAPACITY = PW'(DEPTH);
  localparam bit FRAME_MODE = (OVERFLOW_MODE == 1);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [DATA_WIDTH:0]   head;
  state_t                state;
  state_t                state_next;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         commit_ptr;
  logic [PW-1:0]         frame_start_ptr;
  logic [PW-1:0]         wr_level;
  logic [DATA_WIDTH-1:0] pend_data;
  logic                  pend_valid;
  logic                  flush_next;
  logic                  active_q;

  logic fall;
  logic frame_start;
  logic strobe_take;
  logic wr_req;
  logic wr_eof;
  logic wr_full;
  logic discard;
  logic do_write;
  logic do_read;

  // Readers see only up to commit_ptr; the write-side full check uses wr_ptr.
  assign fall     = active_q & ~in_active;
  assign wr_level = wr_ptr - rd_ptr;
  assign wr_full  = (wr_level == CAPACITY);
  assign level    = commit_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == CAPACITY);
  assign do_read  = read_strobe & ~empty;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign data     = empty ? '0 : head[DATA_WIDTH-1:0];
  assign eof      = ~empty & head[DATA_WIDTH];

  always_comb begin
    frame_start = 1'b0;
    strobe_take = in_strobe;
    wr_req      = 1'b0;
    wr_eof      = 1'b0;
    if (FRAME_MODE) begin
      frame_start = in_strobe & (state == IDLE) & (in_active | active_q);
      strobe_take = in_strobe & ((state == RECV) | frame_start);
    end
    // A strobe coinciding with the frame end parks the new word for one holding cycle.
    if (flush_next) begin
      wr_req = pend_valid;
      wr_eof = 1'b1;
    end else if (strobe_take) begin
      wr_req = pend_valid;
    end else if (fall) begin
      wr_req = pend_valid;
      wr_eof = 1'b1;
    end
    discard  = FRAME_MODE && (state == RECV) && (in_error || (wr_req && wr_full));
    do_write = wr_req & ~wr_full & ~discard;
  end

  always_comb begin
    state_next = state;
    if (FRAME_MODE) begin
      case (state)
        IDLE:    if (frame_start) state_next = RECV;
        RECV: begin
          if (discard)                state_next = in_active ? DISCARD : IDLE;
          else if (do_write && wr_eof) state_next = IDLE;
        end
        DISCARD: if (!in_active) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      commit_ptr      <= '0;
      frame_start_ptr <= '0;
      pend_data       <= '0;
      pend_valid      <= 1'b0;
      flush_next      <= 1'b0;
      active_q        <= 1'b0;
      overflow        <= 1'b0;
      error           <= 1'b0;
    end else if (clear) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      commit_ptr      <= '0;
      frame_start_ptr <= '0;
      pend_data       <= '0;
      pend_valid      <= 1'b0;
      flush_next      <= 1'b0;
      active_q        <= 1'b0;
      overflow        <= 1'b0;
      error           <= 1'b0;
    end else begin
      active_q <= in_active;
      if (discard || flush_next) begin
        pend_valid <= 1'b0;
        flush_next <= 1'b0;
      end else if (strobe_take) begin
        pend_data  <= in_data;
        pend_valid <= 1'b1;
        flush_next <= fall;
      end else if (fall) begin
        pend_valid <= 1'b0;
      end
      if (frame_start) frame_start_ptr <= wr_ptr;
      if (discard)       wr_ptr <= frame_start_ptr;
      else if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_write && (!FRAME_MODE || wr_eof)) commit_ptr <= wr_ptr + 1'b1;
      if (do_read) rd_ptr <= rd_ptr + 1'b1;
      if (wr_req && wr_full) overflow <= 1'b1;
      if (in_error) error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && !clear) mem[wr_ptr[AW-1:0]] <= {wr_eof, pend_data};
  end

endmodule
